// File: rtl/lr_dpath_gen.sv
// rtl/lr_dpath_gen.sv - register/ALU datapath with memory handshake, HALT and delayed IME
// Optional debug read port enabled by defining LR_DPATH_DBG_EN.
module lr_dpath_gen #(
    parameter int DATA_W  = 8,
    parameter int NREGS   = 8,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clock4,
    input  logic              reset,
    input  logic              uop_valid,
    output logic              uop_ready,
    input  logic [4:0]        uop_dst,
    input  logic [4:0]        uop_srca,
    input  logic [4:0]        uop_srcb,
    input  logic [2:0]        uop_alu,
    input  logic [3:0]        uop_fmask,
    input  logic [1:0]        uop_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              irq,
    output logic [3:0]        flags,
    output logic              ime,
    output logic              halted,
    output logic              bus_err,
    input  logic [4:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALT} state_t;

    localparam int         RW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] OP_PASS = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
                           OP_OR   = 3'd4, OP_XOR = 3'd5, OP_INC = 3'd6, OP_DEC = 3'd7;
    localparam logic [1:0] M_NONE = 2'd0, M_LOAD = 2'd1, M_STORE = 2'd2, M_HALT = 2'd3;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] mdr, temp;
    state_t            state, state_nxt;
    logic [7:0]        wait_cnt;
    logic              ld_pend, ime_pend;
    logic [4:0]        ld_dst;

    function automatic logic [DATA_W-1:0] read_sel(input logic [4:0] sel);
        if (int'(sel) < NREGS) return regs[sel[RW-1:0]];
        case (sel)
            5'h1c:   return mdr;
            5'h1d:   return temp;
            5'h1e:   return DATA_W'(1);
            default: return '0;
        endcase
    endfunction

    logic [DATA_W-1:0]   bus_a, bus_b, op_b, alu_res;
    logic [DATA_W:0]     sum;
    logic [4:0]          hsum;
    logic                is_sub, is_arith;
    logic [3:0]          alu_flags, flags_nxt;
    logic [2*DATA_W-1:0] addr_cat;

    always_comb begin
        bus_a    = read_sel(uop_srca);
        bus_b    = read_sel(uop_srcb);
        addr_cat = {bus_a, bus_b};
        is_sub   = (uop_alu == OP_SUB) || (uop_alu == OP_DEC);
        is_arith = (uop_alu == OP_ADD) || (uop_alu == OP_INC) || is_sub;
        op_b     = ((uop_alu == OP_INC) || (uop_alu == OP_DEC)) ? DATA_W'(1) : bus_b;
        sum      = is_sub ? ({1'b0, bus_a} - {1'b0, op_b}) : ({1'b0, bus_a} + {1'b0, op_b});
        hsum     = is_sub ? ({1'b0, bus_a[3:0]} - {1'b0, op_b[3:0]})
                          : ({1'b0, bus_a[3:0]} + {1'b0, op_b[3:0]});
        case (uop_alu)
            OP_PASS: alu_res = bus_a;
            OP_AND:  alu_res = bus_a & bus_b;
            OP_OR:   alu_res = bus_a | bus_b;
            OP_XOR:  alu_res = bus_a ^ bus_b;
            default: alu_res = sum[DATA_W-1:0];
        endcase
        // Subtraction of zero-extended operands leaves the borrow in the top bit.
        alu_flags = {alu_res == '0, is_sub, is_arith & hsum[4], is_arith & sum[DATA_W]};
        for (int i = 0; i < 4; i++) flags_nxt[i] = uop_fmask[i] ? alu_flags[i] : flags[i];
    end

    logic              wr_en, flag_en, done, start, finish, timeout;
    logic [4:0]        wr_sel;
    logic [DATA_W-1:0] wr_val;

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_sel    = uop_dst;
        wr_val    = alu_res;
        flag_en   = 1'b0;
        done      = 1'b0;
        start     = 1'b0;
        finish    = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: if (uop_valid) begin
                case (uop_mem)
                    M_NONE:  begin wr_en = 1'b1; flag_en = 1'b1; done = 1'b1; end
                    M_HALT:  state_nxt = S_HALT;
                    default: begin start = 1'b1; state_nxt = S_WAIT; end
                endcase
            end
            S_WAIT: if (mem_ack) begin
                finish    = 1'b1;
                done      = 1'b1;
                wr_en     = ld_pend;
                wr_sel    = ld_dst;
                wr_val    = mem_rdata;
                state_nxt = S_IDLE;
            end else if (wait_cnt == TO_LAST) begin
                finish    = 1'b1;
                done      = 1'b1;
                timeout   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_HALT: if (irq) begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign uop_ready = (state == S_IDLE);
    assign halted    = (state == S_HALT);

    always_ff @(posedge clock4) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            mdr       <= '0;
            temp      <= '0;
            flags     <= '0;
            ime       <= 1'b0;
            ime_pend  <= 1'b0;
            bus_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wait_cnt  <= '0;
            ld_pend   <= 1'b0;
            ld_dst    <= '0;
            state     <= S_IDLE;
        end else begin
            state <= state_nxt;
            if (start) begin
                mem_req   <= 1'b1;
                mem_we    <= (uop_mem == M_STORE);
                mem_addr  <= addr_cat[ADDR_W-1:0];
                mem_wdata <= bus_b;
                wait_cnt  <= '0;
                ld_pend   <= (uop_mem == M_LOAD);
                ld_dst    <= uop_dst;
            end else if (state == S_WAIT && !finish) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (finish) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            if (timeout) bus_err <= 1'b1;
            if (flag_en) flags <= flags_nxt;
            if (state == S_WAIT && mem_ack && ld_pend) mdr <= mem_rdata;
            if (wr_en) begin
                if (int'(wr_sel) < NREGS) regs[wr_sel[RW-1:0]] <= wr_val;
                else if (wr_sel == 5'h1c) mdr <= wr_val;
                else if (wr_sel == 5'h1d) temp <= wr_val;
            end
            // A pending enable lands when the next uop completes; a write of 0 wins.
            if (done && ime_pend) begin
                ime      <= 1'b1;
                ime_pend <= 1'b0;
            end
            if (wr_en && wr_sel == 5'h1e) begin
                if (wr_val[0]) ime_pend <= 1'b1;
                else begin
                    ime      <= 1'b0;
                    ime_pend <= 1'b0;
                end
            end
        end
    end

`ifdef LR_DPATH_DBG_EN
    assign dbg_data = read_sel(dbg_sel);
`else
    logic unused_dbg;
    assign unused_dbg = ^dbg_sel;
    assign dbg_data   = '0;
`endif
endmodule
